gate_unit_pipe: RTL and testbench

GATE_UNIT_PIPE -- requirements
Module: gate_unit_pipe

---
 rtl/gate_unit_pipe.sv | 94 +++++++++
 tb/tb_gate_unit_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_pipe.sv
// Logic-gate evaluator with a 2-entry in-order result buffer.
// Bitwise or reduction results, illegal-op flagging, saturating done counter.
module gate_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             op_err,
  output logic [CNT_W-1:0] done_count
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] res;
  logic             err;

  always_comb begin
    r   = '0;
    err = 1'b0;
    unique case (1'b1)
      (op == 3'd0): r = a & b;
      (op == 3'd1): r = a | b;
      (op == 3'd2): r = ~(a & b);
      (op == 3'd3): r = ~(a | b);
      (op == 3'd4): r = a ^ b;
      (op == 3'd5): r = ~(a ^ b);
      default:      err = 1'b1;
    endcase
  end

  always_comb begin
    res = '0;
    if (!err) begin
      if (mode) begin
        res[0] = |r;
        res[1] = &r;
      end else begin
        res = r;
      end
    end
  end

  // Each slot stores {result, error flag}
  logic [WIDTH:0] mem [2];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     count;
  logic           push;
  logic           pop;

  assign in_ready  = !rst && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign c         = mem[rd_ptr][WIDTH:1];
  assign op_err    = mem[rd_ptr][0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {res, err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count <= '0;
    end else if (pop && (done_count != {CNT_W{1'b1}})) begin
      done_count <= done_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Self-checking bench for gate_unit_pipe.
// Directed spec cases plus random traffic against a queue model.
module tb_gate_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;

  logic        in_ready, out_valid, op_err;
  logic [7:0]  c;
  logic [15:0] done_count;
  logic        in_ready2, out_valid2, op_err2;
  logic [7:0]  c2;
  logic [1:0]  done2;

  gate_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .op_err(op_err), .done_count(done_count)
  );

  gate_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .mode(mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .c(c2), .op_err(op_err2), .done_count(done2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] c;
    logic       e;
  } ent_t;

  ent_t q[$];
  ent_t popped[$];
  int   total;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_op(input logic [7:0] x, input logic [7:0] y,
                                  input int o, input logic m);
    ent_t e;
    logic [7:0] r;
    e.c = 8'h00;
    e.e = 1'b0;
    case (o)
      0: r = x & y;
      1: r = x | y;
      2: r = ~(x & y);
      3: r = ~(x | y);
      4: r = x ^ y;
      5: r = ~(x ^ y);
      default: begin
        e.e = 1'b1;
        return e;
      end
    endcase
    if (m) e.c = {6'd0, r == 8'hFF, r != 8'h00};
    else   e.c = r;
    return e;
  endfunction

  task automatic check_outputs();
    int sz;
    sz = q.size();
    chk("in_ready", {31'd0, in_ready}, (sz < 2) ? 1 : 0);
    chk("out_valid", {31'd0, out_valid}, (sz > 0) ? 1 : 0);
    if (sz > 0) begin
      chk("c", {24'd0, c}, {24'd0, q[0].c});
      chk("op_err", {31'd0, op_err}, {31'd0, q[0].e});
    end
    chk("done_count", {16'd0, done_count}, (total > 65535) ? 65535 : total);
    chk("done_sat", {30'd0, done2}, (total > 3) ? 3 : total);
  endtask

  task automatic step(input logic iv, input logic [7:0] ta,
                      input logic [7:0] tb, input logic [2:0] top,
                      input logic tm, input logic ordy);
    logic do_push, do_pop;
    ent_t e;
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    a         = ta;
    b         = tb;
    op        = top;
    mode      = tm;
    out_ready = ordy;
    do_push   = iv && (q.size() < 2);
    do_pop    = (q.size() > 0) && ordy;
    e         = ref_op(ta, tb, int'(top), tm);
    @(posedge clk);
    if (do_pop) begin
      popped.push_back(q[0]);
      void'(q.pop_front());
      total++;
    end
    if (do_push) q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
  endtask

  logic [7:0] exp37 [6];
  logic [7:0] m_a   [4];
  logic [7:0] m_b   [4];
  logic [2:0] m_op  [4];
  logic [7:0] m_exp [4];
  logic [1:0] sat   [5];
  int         d0;

  initial begin
    exp37 = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};
    m_a   = '{8'hFF, 8'h0F, 8'h00, 8'hAA};
    m_b   = '{8'hFF, 8'h00, 8'h00, 8'hAA};
    m_op  = '{3'd0, 3'd1, 3'd3, 3'd4};
    m_exp = '{8'h03, 8'h01, 8'h03, 8'h00};
    sat   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    n_tests = 0;
    n_fail  = 0;
    total   = 0;

    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_c", {24'd0, c}, 0);
    chk("rst_op_err", {31'd0, op_err}, 0);
    chk("rst_done", {16'd0, done_count}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Bitwise sweep of all legal gates
    popped.delete();
    for (int i = 0; i < 6; i++)
      step(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b0, 1'b1);
    drain();
    chk("sweep_count", popped.size(), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++) begin
      chk("sweep_c", {24'd0, popped[i].c}, {24'd0, exp37[i]});
      chk("sweep_err", {31'd0, popped[i].e}, 0);
    end
    @(negedge clk);
    chk("sweep_done", {16'd0, done_count}, 6);

    // Reduction mode
    popped.delete();
    for (int i = 0; i < 4; i++)
      step(1'b1, m_a[i], m_b[i], m_op[i], 1'b1, 1'b1);
    drain();
    chk("red_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("red_c", {24'd0, popped[i].c}, {24'd0, m_exp[i]});

    // Illegal op then legal op
    popped.delete();
    d0 = total;
    step(1'b1, 8'hFF, 8'hFF, 3'd6, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ill_done_inc", {16'd0, done_count}, d0 + 1);
    step(1'b1, 8'h12, 8'h34, 3'd1, 1'b0, 1'b1);
    drain();
    if (popped.size() == 2) begin
      chk("ill_c", {24'd0, popped[0].c}, 0);
      chk("ill_err", {31'd0, popped[0].e}, 1);
      chk("legal_err", {31'd0, popped[1].e}, 0);
    end else begin
      chk("ill_count", popped.size(), 2);
    end

    // Backpressure: third offer held until space frees
    popped.delete();
    step(1'b1, 8'h01, 8'hFF, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 8'hFF, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h03, 8'hFF, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h03, 8'hFF, 3'd0, 1'b0, 1'b0);
    chk("bp_held", {31'd0, in_ready}, 0);
    step(1'b1, 8'h03, 8'hFF, 3'd0, 1'b0, 1'b1);
    step(1'b1, 8'h03, 8'hFF, 3'd0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    drain();
    chk("bp_count", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      chk("bp_order", {24'd0, popped[i].c}, i + 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    drain();

    // Asynchronous reset with a full buffer
    step(1'b1, 8'h55, 8'hAA, 3'd1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 8'hAA, 3'd4, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_done", {16'd0, done_count}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 0);
    chk("arst_c", {24'd0, c}, 0);
    q.delete();
    total = 0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 1);
    chk("rel_out_valid", {31'd0, out_valid}, 0);

    // Saturation on the narrow counter
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 3'd2, 1'b0, 1'b1);
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
      @(negedge clk);
      chk("sat_seq", {30'd0, done2}, {30'd0, sat[k]});
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
